// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller
// syncs sources, latches level/edge events, drives masked HWInt
module irq_ctrl #(
  parameter int          N_SRC = 6,
  parameter logic [31:0] BASE  = 32'h0000_7F20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [29:0]      PrAddr,
  input  logic [31:0]      PrWD,
  input  logic [3:0]       PrBE,
  input  logic             PrWE,
  output logic [31:0]      rd_data,
  output logic             hit,
  output logic [5:0]       HWInt
);

  localparam logic [2:0] OFF_PEND = 3'd0;
  localparam logic [2:0] OFF_MASK = 3'd1;
  localparam logic [2:0] OFF_MODE = 3'd2;
  localparam logic [2:0] OFF_STAT = 3'd3;
  localparam logic [2:0] OFF_LOST = 3'd4;

  logic [N_SRC-1:0] r_sy0;
  logic [N_SRC-1:0] r_s1;
  logic [N_SRC-1:0] r_s2;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_mode;
  logic [N_SRC-1:0] r_lost;
  logic [N_SRC-1:0] r_hw;

  logic             w_hit;
  logic [2:0]       w_off;
  logic             w_we;
  logic             w_wr_pend;
  logic             w_wr_mask;
  logic             w_wr_mode;
  logic             w_wr_lost;
  logic [N_SRC-1:0] w_wd;
  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_clr_pend;
  logic [N_SRC-1:0] w_clr_lost;
  logic [N_SRC-1:0] w_pend_nx;
  logic [N_SRC-1:0] w_lost_nx;
  logic [N_SRC-1:0] w_act;
  logic [2:0]       w_idx;
  logic [31:0]      w_rd;
  logic [5:0]       w_hw;
  logic             w_unused;

  assign w_hit = (PrAddr[29:3] == BASE[31:5]);
  assign w_off = PrAddr[2:0];
  // only full-word writes count; partial-byte writes are dropped
  assign w_we  = w_hit & PrWE & (PrBE == 4'b1111);
  assign w_wd  = PrWD[N_SRC-1:0];

  assign w_wr_pend = w_we & (w_off == OFF_PEND);
  assign w_wr_mask = w_we & (w_off == OFF_MASK);
  assign w_wr_mode = w_we & (w_off == OFF_MODE);
  assign w_wr_lost = w_we & (w_off == OFF_LOST);

  assign w_clr_pend = w_wr_pend ? w_wd : '0;
  assign w_clr_lost = w_wr_lost ? w_wd : '0;

  assign w_edge = r_s1 & ~r_s2;
  assign w_act  = r_pend & r_mask;

  // level sources copy s1; edge sources set on edge, set beats W1C
  assign w_pend_nx = (~r_mode & r_s1)
                   | (r_mode & (w_edge | (r_pend & ~w_clr_pend)));

  // an edge landing on an already-pending edge source is a loss
  assign w_lost_nx = (r_mode & w_edge & r_pend)
                   | (r_lost & ~w_clr_lost);

  assign w_unused = ^PrWD[31:N_SRC];

  // lowest active source index, scanned high to low so low wins
  always_comb begin
    w_idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_act[i]) w_idx = 3'(i);
    end
  end

  // combinational read mux over the register window
  always_comb begin
    w_rd = '0;
    if (w_hit) begin
      case (w_off)
        OFF_PEND: w_rd[N_SRC-1:0] = r_pend;
        OFF_MASK: w_rd[N_SRC-1:0] = r_mask;
        OFF_MODE: w_rd[N_SRC-1:0] = r_mode;
        OFF_STAT: begin
          w_rd[31]  = |w_act;
          w_rd[2:0] = w_idx;
        end
        OFF_LOST: w_rd[N_SRC-1:0] = r_lost;
        default:  w_rd = '0;
      endcase
    end
  end

  // pad HWInt so unimplemented sources read as 0
  always_comb begin
    w_hw = '0;
    w_hw[N_SRC-1:0] = r_hw;
  end

  // two-flop synchronizer plus previous-value flop for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sy0 <= '0;
      r_s1  <= '0;
      r_s2  <= '0;
    end else begin
      r_sy0 <= irq_src;
      r_s1  <= r_sy0;
      r_s2  <= r_s1;
    end
  end

  // pending and lost event state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_lost <= '0;
    end else begin
      r_pend <= w_pend_nx;
      r_lost <= w_lost_nx;
    end
  end

  // software-written configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
      r_mode <= '0;
    end else begin
      if (w_wr_mask) r_mask <= w_wd;
      if (w_wr_mode) r_mode <= w_wd;
    end
  end

  // registered interrupt vector to the core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hw <= '0;
    else     r_hw <= w_act;
  end

  assign rd_data = w_rd;
  assign hit     = w_hit;
  assign HWInt   = w_hw;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed checks for irq_ctrl
// linear stimulus with immediate assertions
module tb_irq_ctrl;

  localparam logic [29:0] WB = 30'h1FC8;

  logic        clk;
  logic        rst;
  logic [5:0]  irq_src;
  logic [29:0] PrAddr;
  logic [31:0] PrWD;
  logic [3:0]  PrBE;
  logic        PrWE;
  logic [31:0] rd_data;
  logic        hit;
  logic [5:0]  HWInt;

  int total;
  int bad;

  irq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .irq_src (irq_src),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .PrBE    (PrBE),
    .PrWE    (PrWE),
    .rd_data (rd_data),
    .hit     (hit),
    .HWInt   (HWInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag,
                    input logic [2:0] off,
                    input logic [31:0] exp);
    PrAddr = WB + 30'(off);
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic wr(input logic [2:0] off,
                    input logic [31:0] d,
                    input logic [3:0] be);
    PrAddr = WB + 30'(off);
    PrWD   = d;
    PrBE   = be;
    PrWE   = 1'b1;
    @(posedge clk);
    #1;
    PrWE   = 1'b0;
    PrBE   = 4'hF;
  endtask

  task automatic hw(input string tag, input logic [5:0] exp);
    chk(tag, {26'b0, HWInt}, {26'b0, exp});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    irq_src = '0;
    PrAddr  = WB;
    PrWD    = '0;
    PrBE    = 4'hF;
    PrWE    = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);

    rd("rst_pend", 3'd0, 32'h0);
    rd("rst_mask", 3'd1, 32'h0);
    rd("rst_mode", 3'd2, 32'h0);
    rd("rst_stat", 3'd3, 32'h0);
    rd("rst_lost", 3'd4, 32'h0);
    hw("rst_hw", 6'h00);
    rd("rsv_18", 3'd6, 32'h0);
    chk("hit_18", {31'b0, hit}, 32'd1);
    PrAddr = WB + 30'd8;
    #1;
    chk("hit_20", {31'b0, hit}, 32'd0);
    chk("rd_20", rd_data, 32'h0);

    wr(3'd1, 32'h01, 4'hF);
    irq_src[0] = 1'b1;
    tick(3);
    hw("lvl_k2", 6'h00);
    rd("lvl_pend", 3'd0, 32'h01);
    tick(1);
    hw("lvl_k3", 6'h01);
    wr(3'd0, 32'h01, 4'hF);
    rd("lvl_w1c", 3'd0, 32'h01);
    rd("lvl_lost", 3'd4, 32'h0);
    irq_src[0] = 1'b0;
    tick(3);
    hw("lvl_drop3", 6'h01);
    tick(1);
    hw("lvl_drop4", 6'h00);
    rd("lvl_pend0", 3'd0, 32'h0);

    wr(3'd1, 32'h00, 4'hF);
    wr(3'd2, 32'h3F, 4'hF);
    irq_src[3] = 1'b1;
    tick(3);
    irq_src[3] = 1'b0;
    tick(5);
    rd("edg_pend", 3'd0, 32'h08);
    hw("edg_hw0", 6'h00);
    wr(3'd1, 32'h08, 4'hF);
    hw("msk_k", 6'h00);
    tick(1);
    hw("msk_k1", 6'h08);
    rd("stat", 3'd3, 32'h8000_0003);

    wr(3'd0, 32'h08, 4'hF);
    rd("edg_w1c", 3'd0, 32'h0);
    irq_src[1] = 1'b1;
    tick(3);
    irq_src[1] = 1'b0;
    tick(5);
    rd("p1_pend", 3'd0, 32'h02);
    rd("p1_lost", 3'd4, 32'h0);
    irq_src[1] = 1'b1;
    tick(3);
    irq_src[1] = 1'b0;
    tick(5);
    rd("p2_lost", 3'd4, 32'h02);
    rd("p2_pend", 3'd0, 32'h02);
    irq_src[1] = 1'b1;
    tick(2);
    wr(3'd4, 32'h02, 4'hF);
    rd("p3_lost", 3'd4, 32'h02);
    wr(3'd4, 32'h02, 4'hF);
    rd("lost_w1c", 3'd4, 32'h0);
    irq_src[1] = 1'b0;
    tick(5);
    rd("p3_pend", 3'd0, 32'h02);

    wr(3'd1, 32'h3F, 4'b0011);
    rd("part_wr", 3'd1, 32'h08);
    wr(3'd5, 32'hFFFF_FFFF, 4'hF);
    rd("rsv_wr", 3'd5, 32'h0);

    wr(3'd1, 32'h3F, 4'hF);
    irq_src = 6'h3F;
    tick(3);
    irq_src = 6'h00;
    tick(5);
    rd("all_pend", 3'd0, 32'h3F);
    hw("all_hw", 6'h3F);
    rd("all_stat", 3'd3, 32'h8000_0000);
    #2;
    rst = 1'b1;
    #1;
    hw("async_hw", 6'h00);
    rd("async_pend", 3'd0, 32'h0);
    rd("async_mask", 3'd1, 32'h0);
    tick(1);
    rst = 1'b0;
    tick(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller between the peripheral interrupt lines and the CPU core's `HWInt[7:2]` input. It synchronizes up to six asynchronous sources and latches them as level or edge events. It applies a software mask and drives a registered `HWInt` vector. The CPU configures, inspects and acknowledges it through the processor bus (`PrAddr`/`PrWD`/`PrWE`/`PrBE`), and its read data is returned on `PrRD` through the system bridge.

## Interface
- `N_SRC`, default 6: number of implemented sources, 1..6. Source i drives `HWInt[2+i]`; unused `HWInt` bits are tied to 0.
- `BASE`, default 32'h0000_7F20: byte base address of the 32-byte register window. Must be 32-byte aligned.

- `clk`  in  1: the single clock. All state is updated on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `irq_src`  in  N_SRC: raw interrupt requests, asynchronous to `clk`.
- `PrAddr`  in  30: word address `[31:2]` from the CPU M stage.
- `PrWD`  in  32: write data.
- `PrBE`  in  4: byte enables.
- `PrWE`  in  1: write strobe. Already qualified with `~IntReq` by the CPU.
- `rd_data`  out  32: read data. Combinational from `PrAddr`; 0 when `hit`=0.
- `hit`  out  1: `PrAddr` lies in the window, i.e. `{PrAddr,2'b0}[31:5] == BASE[31:5]`.
- `HWInt`  out  6: registered interrupt vector to the CPU, bits `[7:2]`.

## Operation
- Register map, offset = `{PrAddr[4:2],2'b0}`:
  - 0x00 PEND: RO; write-1-to-clear.
  - 0x04 MASK: RW. 1 = enabled.
  - 0x08 MODE: RW. 1 = rising-edge, 0 = level.
  - 0x0C STATUS: RO.
    - bit31 = any of `PEND&MASK` is set.
    - `[2:0]` = lowest index i with `PEND[i]&MASK[i]`, or 0 if none.
  - 0x10 LOST: RO; write-1-to-clear.
  - 0x14–0x1C: read 0; writes ignored.
- Width of implemented registers:
  - Only bits `[N_SRC-1:0]` of PEND, MASK, MODE and LOST exist.
  - Other bits read 0 and ignore writes.
- Write rules:
  - A write takes effect only when `hit && PrWE && PrBE==4'b1111`.
  - Partial-byte writes are ignored entirely.
- Synchronizer: a 2-flop chain per source gives `s1[i]`. A third flop `s2[i]` holds the previous `s1[i]`.
  - `edge[i] = s1[i] & ~s2[i]`.
- Level mode (`MODE[i]`=0):
  - `PEND[i]` <= `s1[i]` every cycle.
  - W1C has no lasting effect while the source stays high.
  - LOST[i] is never set.
- Edge mode (`MODE[i]`=1):
  - `PEND[i]` is set on `edge[i]` and cleared by W1C.
  - Set and W1C in the same cycle: set wins.
  - `edge[i]` while `PEND[i]` is already 1: `LOST[i]` <= 1. PEND stays 1.
  - W1C to LOST and a new loss in the same cycle: set wins.
- Switching MODE from 1 to 0: PEND follows the level from the next cycle.
- Switching MODE from 0 to 1: PEND keeps its current value.
- `HWInt[2+i]` <= `PEND[i] & MASK[i]` (registered). Masked sources still pend.
- `rd_data` for PEND, MASK and STATUS reflects register state before the current cycle's write.

## Timing
- Reset values (immediate on `rst`, held while it is high):
  - PEND, MASK, MODE, LOST = 0.
  - Synchronizer flops = 0.
  - `HWInt` = 0.
- `rd_data` and `hit` follow `PrAddr` combinationally, with no cycle of latency.
- Latency from `irq_src[i]` rising before clock edge k:
  - `s1` = 1 after edge k+1.
  - `PEND` = 1 after edge k+2.
  - `HWInt` = 1 after edge k+3.
- Edge-mode pulses must be at least 2 `clk` periods wide to be guaranteed captured. Narrower pulses may be missed.
- MASK write at edge k: `HWInt` reflects the new mask after edge k+1.
- W1C of PEND at edge k: `HWInt` drops after edge k+1, unless the source re-pends.
- Reset asserted mid-operation: all state clears asynchronously. A source that is still high after reset release re-pends via the normal 3-edge path in level mode only; MODE is 0 after reset.

## Test plan
- Reset, then read all five registers:
  - Every read = 0 and `HWInt` = 6'b0.
  - Read at 0x18 = 0 with `hit`=1.
  - Address `BASE+0x20` gives `hit`=0.
- MASK=6'h01, MODE=0, raise `irq_src[0]` before edge k:
  - `HWInt[2]`=1 after edge k+3.
  - W1C PEND=1 while the source is high: PEND re-reads 1.
  - Drop the source: `HWInt[2]`=0 four edges later.
- MODE=6'h3F, MASK=0, 3-cycle pulse on `irq_src[3]`:
  - PEND=0x08, `HWInt`=0.
  - Write MASK=0x08: `HWInt[5]`=1 one edge later.
  - STATUS = 0x8000_0003.
- Edge mode, second pulse on source 1 before acknowledge:
  - LOST=0x02, PEND=0x02.
  - W1C of LOST in the same cycle as a third edge: LOST stays 0x02.
- Partial write to MASK with `PrBE`=4'b0011 and `PrWD`=0x3F: MASK unchanged.
- Assert `rst` asynchronously mid-cycle while PEND=0x3F and MASK=0x3F: `HWInt` goes to 0 without waiting for a clock edge.
